// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator_if
//  Description : Stream bundle between the multiplier, the product
//                accumulator and the result consumer.
//                  p_data/p_valid/p_ready : product input stream
//                  sum/sum_valid/sum_ready: result output stream
//                slave  = accumulator side, master = producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface product_accumulator_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
);
    logic [DATA_W-1:0] p_data;
    logic              p_valid;
    logic              p_ready;
    logic [ACC_W-1:0]  sum;
    logic              sum_valid;
    logic              sum_ready;

    modport slave (
        input  p_data, p_valid, sum_ready,
        output p_ready, sum, sum_valid
    );

    modport master (
        output p_data, p_valid, sum_ready,
        input  p_ready, sum, sum_valid
    );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator
//  Description : Sums a programmed number of 8-bit products arriving on a
//                valid/ready stream and presents the total on a valid/ready
//                result port. First registered stage after the combinational
//                4x4 multiplier.
//  Ports       : clk, rst (async, active high)
//                start  - 1-cycle pulse, arms a run (only in IDLE)
//                len    - run length sampled with start, 0 = 2**CNT_W beats
//                busy   - high while accumulating or holding a result
//                ovf    - sticky per run, accumulator carried out
//                bus    - product_accumulator_if.slave (product in, sum out)
//  Options     : `define ACC_SAT_EN clamps the accumulator at 2**ACC_W-1 on
//                carry-out; otherwise the sum wraps modulo 2**ACC_W.
//  Revision    : 1.0  initial release
// ============================================================================
module product_accumulator #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int ACC_W  = 12
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] len,
    output logic                  busy,
    output logic                  ovf,
    product_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_last;
    logic [ACC_W-1:0]   r_sum;
    logic               r_ovf;
    logic               r_p_ready;
    logic               r_sum_valid;

    logic               w_beat;
    logic               w_last_beat;
    logic [ACC_W:0]     w_add;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_beat      = bus.p_valid & r_p_ready;
    assign w_last_beat = w_beat & (r_cnt == r_last);

    // One extra bit captures the carry-out of the accumulate.
    assign w_add   = {1'b0, r_acc} + (ACC_W+1)'(bus.p_data);
    assign w_carry = w_add[ACC_W];

`ifdef ACC_SAT_EN
    // Once clamped, every further non-zero product carries again, so the
    // accumulator stays pinned at the maximum for the rest of the run.
    assign w_acc_nxt = w_carry ? c_acc_max : w_add[ACC_W-1:0];
`else
    assign w_acc_nxt = w_add[ACC_W-1:0];
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                if (bus.sum_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_p_ready   <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_ovf     <= 1'b0;
                        r_p_ready <= 1'b1;
                        // len-1 wraps to all ones for len==0, which is the
                        // index of the last beat of a 2**CNT_W-beat run.
                        r_last    <= len - 1'b1;
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        r_ovf <= r_ovf | w_carry;
                    end
                    if (w_last_beat) begin
                        r_sum       <= w_acc_nxt;
                        r_p_ready   <= 1'b0;
                        r_sum_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.sum_ready) begin
                        r_sum_valid <= 1'b0;
                    end
                end
                default: begin
                    r_p_ready   <= 1'b0;
                    r_sum_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_ready   = r_p_ready;
    assign bus.sum       = r_sum;
    assign bus.sum_valid = r_sum_valid;
    assign ovf           = r_ovf;

endmodule
`default_nettype wire
